// File: rtl/taxi_baser_pkg.sv
// taxi_baser_pkg: shared 10GBASE-R constants and types.
// XGMII characters, 64b/66b codes, block types, classes, rx states.
// Macro TAXI_BASER_DEC_LPI_EN: when defined, control code 06 decodes to LPI.
package taxi_baser_pkg;

  localparam logic [7:0] XGMII_IDLE   = 8'h07;
  localparam logic [7:0] XGMII_LPI    = 8'h06;
  localparam logic [7:0] XGMII_START  = 8'hfb;
  localparam logic [7:0] XGMII_TERM   = 8'hfd;
  localparam logic [7:0] XGMII_ERROR  = 8'hfe;
  localparam logic [7:0] XGMII_SEQ_OS = 8'h9c;
  localparam logic [7:0] XGMII_SIG_OS = 8'h5c;
  localparam logic [7:0] XGMII_RES_0  = 8'h1c;
  localparam logic [7:0] XGMII_RES_1  = 8'h3c;
  localparam logic [7:0] XGMII_RES_2  = 8'h7c;
  localparam logic [7:0] XGMII_RES_3  = 8'hbc;
  localparam logic [7:0] XGMII_RES_4  = 8'hdc;
  localparam logic [7:0] XGMII_RES_5  = 8'hf7;

  localparam logic [6:0] CTRL_IDLE  = 7'h00;
  localparam logic [6:0] CTRL_LPI   = 7'h06;
  localparam logic [6:0] CTRL_ERROR = 7'h1e;
  localparam logic [6:0] CTRL_RES_0 = 7'h2d;
  localparam logic [6:0] CTRL_RES_1 = 7'h33;
  localparam logic [6:0] CTRL_RES_2 = 7'h4b;
  localparam logic [6:0] CTRL_RES_3 = 7'h55;
  localparam logic [6:0] CTRL_RES_4 = 7'h66;
  localparam logic [6:0] CTRL_RES_5 = 7'h78;

  localparam logic [3:0] O_SEQ_OS = 4'h0;
  localparam logic [3:0] O_SIG_OS = 4'hf;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] BT_CTRL     = 8'h1e;
  localparam logic [7:0] BT_OS_4     = 8'h2d;
  localparam logic [7:0] BT_START_4  = 8'h33;
  localparam logic [7:0] BT_OS_START = 8'h66;
  localparam logic [7:0] BT_OS_04    = 8'h55;
  localparam logic [7:0] BT_START_0  = 8'h78;
  localparam logic [7:0] BT_OS_0     = 8'h4b;
  localparam logic [7:0] BT_TERM_0   = 8'h87;
  localparam logic [7:0] BT_TERM_1   = 8'h99;
  localparam logic [7:0] BT_TERM_2   = 8'haa;
  localparam logic [7:0] BT_TERM_3   = 8'hb4;
  localparam logic [7:0] BT_TERM_4   = 8'hcc;
  localparam logic [7:0] BT_TERM_5   = 8'hd2;
  localparam logic [7:0] BT_TERM_6   = 8'he1;
  localparam logic [7:0] BT_TERM_7   = 8'hff;

`ifdef TAXI_BASER_DEC_LPI_EN
  localparam bit LPI_EN = 1'b1;
`else
  localparam bit LPI_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    BLK_C, BLK_S, BLK_T, BLK_D, BLK_E
  } blk_class_t;

  typedef enum logic [2:0] {
    RX_INIT, RX_C, RX_D, RX_T, RX_E
  } rx_state_t;

  typedef struct packed {
    logic [63:0] rxd;
    logic [7:0]  rxc;
    blk_class_t  cls;
    logic        bad;
  } blk_t;

  // Returns {bad, xgmii_char}.
  function automatic logic [8:0] ctrl_dec(input logic [6:0] c);
    logic [8:0] r;
    case (c)
      CTRL_IDLE:  r = {1'b0, XGMII_IDLE};
      CTRL_ERROR: r = {1'b0, XGMII_ERROR};
      CTRL_RES_0: r = {1'b0, XGMII_RES_0};
      CTRL_RES_1: r = {1'b0, XGMII_RES_1};
      CTRL_RES_2: r = {1'b0, XGMII_RES_2};
      CTRL_RES_3: r = {1'b0, XGMII_RES_3};
      CTRL_RES_4: r = {1'b0, XGMII_RES_4};
      CTRL_RES_5: r = {1'b0, XGMII_RES_5};
      CTRL_LPI:   r = LPI_EN ? {1'b0, XGMII_LPI}
                             : {1'b1, XGMII_ERROR};
      default:    r = {1'b1, XGMII_ERROR};
    endcase
    return r;
  endfunction

  // Returns {bad, xgmii_char}.
  function automatic logic [8:0] o_dec(input logic [3:0] o);
    logic [8:0] r;
    case (o)
      O_SEQ_OS: r = {1'b0, XGMII_SEQ_OS};
      O_SIG_OS: r = {1'b0, XGMII_SIG_OS};
      default:  r = {1'b1, XGMII_ERROR};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/taxi_baser_blk_decode.sv
// taxi_baser_blk_decode: combinational decode of one 66-bit block.
// In: data[63:0], hdr[1:0]. Out: rxd, rxc, class, bad (bad forces class E).
module taxi_baser_blk_decode
  import taxi_baser_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  hdr,
  output logic [63:0] rxd,
  output logic [7:0]  rxc,
  output blk_class_t  cls,
  output logic        bad
);

  logic [63:0] cx;
  logic [7:0]  cbad;
  logic [63:0] dl;
  logic [8:0]  o0;
  logic [8:0]  o4;
  logic        term;
  logic [2:0]  tk;

  // Data lanes of T blocks start right after the type byte.
  assign dl = {8'h00, data[63:8]};
  assign o0 = o_dec(data[35:32]);
  assign o4 = o_dec(data[39:36]);

  // Lane i control code always sits at bit 8+7*i.
  always_comb begin
    cx   = '0;
    cbad = '0;
    for (int i = 0; i < 8; i++) begin
      {cbad[i], cx[8*i +: 8]} = ctrl_dec(data[8+7*i +: 7]);
    end
  end

  always_comb begin
    rxd  = {8{XGMII_ERROR}};
    rxc  = 8'hff;
    cls  = BLK_E;
    bad  = 1'b1;
    term = 1'b0;
    tk   = 3'd0;
    if (hdr == SYNC_DATA) begin
      rxd = data;
      rxc = 8'h00;
      cls = BLK_D;
      bad = 1'b0;
    end else if (hdr == SYNC_CTRL) begin
      bad = 1'b0;
      case (data[7:0])
        BT_CTRL: begin
          rxd = cx;
          cls = BLK_C;
          bad = |cbad;
        end
        BT_OS_4: begin
          rxd = {data[63:40], o4[7:0], cx[31:0]};
          rxc = 8'h1f;
          cls = BLK_C;
          bad = (|cbad[3:0]) | o4[8];
        end
        BT_START_4: begin
          rxd = {data[63:40], XGMII_START, cx[31:0]};
          rxc = 8'h1f;
          cls = BLK_S;
          bad = |cbad[3:0];
        end
        BT_OS_START: begin
          rxd = {data[63:40], XGMII_START,
                 data[31:8], o0[7:0]};
          rxc = 8'h11;
          cls = BLK_S;
          bad = o0[8];
        end
        BT_OS_04: begin
          rxd = {data[63:40], o4[7:0],
                 data[31:8], o0[7:0]};
          rxc = 8'h11;
          cls = BLK_C;
          bad = o0[8] | o4[8];
        end
        BT_START_0: begin
          rxd = {data[63:8], XGMII_START};
          rxc = 8'h01;
          cls = BLK_S;
        end
        BT_OS_0: begin
          rxd = {cx[63:32], data[31:8], o0[7:0]};
          rxc = 8'hf1;
          cls = BLK_C;
          bad = o0[8] | (|cbad[7:4]);
        end
        BT_TERM_0: begin term = 1'b1; tk = 3'd0; end
        BT_TERM_1: begin term = 1'b1; tk = 3'd1; end
        BT_TERM_2: begin term = 1'b1; tk = 3'd2; end
        BT_TERM_3: begin term = 1'b1; tk = 3'd3; end
        BT_TERM_4: begin term = 1'b1; tk = 3'd4; end
        BT_TERM_5: begin term = 1'b1; tk = 3'd5; end
        BT_TERM_6: begin term = 1'b1; tk = 3'd6; end
        BT_TERM_7: begin term = 1'b1; tk = 3'd7; end
        default:   bad = 1'b1;
      endcase
      if (term) begin
        cls = BLK_T;
        for (int j = 0; j < 8; j++) begin
          if (j < 32'(tk)) begin
            rxd[8*j +: 8] = dl[8*j +: 8];
            rxc[j]        = 1'b0;
          end else if (j == 32'(tk)) begin
            rxd[8*j +: 8] = XGMII_TERM;
          end else begin
            rxd[8*j +: 8] = XGMII_IDLE;
            if (data[8+7*j +: 7] != CTRL_IDLE) bad = 1'b1;
          end
        end
      end
    end
    if (bad) begin
      rxd = {8{XGMII_ERROR}};
      rxc = 8'hff;
      cls = BLK_E;
    end
  end

endmodule

// File: rtl/taxi_xgmii_baser_dec.sv
// taxi_xgmii_baser_dec: 10GBASE-R 64b/66b receive decoder to XGMII.
// In: encoded_rx_data/_valid/_hdr. Out: xgmii_rxd/rxc/rx_valid, rx_bad_block,
// rx_sequence_error. Build macro TAXI_BASER_DEC_LPI_EN enables LPI decode.
module taxi_xgmii_baser_dec
  import taxi_baser_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = DATA_W/8,
  parameter int HDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] encoded_rx_data,
  input  logic              encoded_rx_data_valid,
  input  logic [HDR_W-1:0]  encoded_rx_hdr,
  output logic [DATA_W-1:0] xgmii_rxd,
  output logic [CTRL_W-1:0] xgmii_rxc,
  output logic              xgmii_rx_valid,
  output logic              rx_bad_block,
  output logic              rx_sequence_error
);

  if (DATA_W != 64 || CTRL_W != 8 || HDR_W != 2) begin : g_param_chk
    $fatal(1, "taxi_xgmii_baser_dec: need DATA_W=64 CTRL_W=8 HDR_W=2");
  end

  logic [63:0] dec_rxd;
  logic [7:0]  dec_rxc;
  blk_class_t  dec_cls;
  logic        dec_bad;
  blk_t        dec;

  taxi_baser_blk_decode u_dec (
    .data (encoded_rx_data),
    .hdr  (encoded_rx_hdr),
    .rxd  (dec_rxd),
    .rxc  (dec_rxc),
    .cls  (dec_cls),
    .bad  (dec_bad)
  );

  assign dec = '{rxd: dec_rxd, rxc: dec_rxc, cls: dec_cls, bad: dec_bad};

  blk_t        s1_q, s1_d;
  logic        s1_full_q, s1_full_d;
  rx_state_t   state_q, state_d;
  logic [63:0] rxd_q, rxd_d;
  logic [7:0]  rxc_q, rxc_d;
  logic        valid_q, valid_d;
  logic        bad_q, bad_d;
  logic        seq_q, seq_d;
  logic        nxt_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '{rxd: {8{XGMII_IDLE}}, rxc: 8'hff,
                     cls: BLK_C, bad: 1'b0};
      s1_full_q <= 1'b0;
      state_q   <= RX_INIT;
      rxd_q     <= {8{XGMII_IDLE}};
      rxc_q     <= 8'hff;
      valid_q   <= 1'b0;
      bad_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s1_full_q <= s1_full_d;
      state_q   <= state_d;
      rxd_q     <= rxd_d;
      rxc_q     <= rxc_d;
      valid_q   <= valid_d;
      bad_q     <= bad_d;
      seq_q     <= seq_d;
    end
  end

  // Current block R is in stage 1; the block arriving now is lookahead N.
  assign nxt_ok = (dec.cls == BLK_C) || (dec.cls == BLK_S);

  always_comb begin
    s1_d      = s1_q;
    s1_full_d = s1_full_q;
    state_d   = state_q;
    rxd_d     = rxd_q;
    rxc_d     = rxc_q;
    valid_d   = 1'b0;
    bad_d     = 1'b0;
    seq_d     = 1'b0;
    if (encoded_rx_data_valid) begin
      s1_d      = dec;
      s1_full_d = 1'b1;
      if (s1_full_q) begin
        valid_d = 1'b1;
        bad_d   = s1_q.bad;
        state_d = RX_E;
        case (state_q)
          RX_D: begin
            if (s1_q.cls == BLK_D) state_d = RX_D;
            else if (s1_q.cls == BLK_T && nxt_ok) state_d = RX_T;
          end
          RX_E: begin
            if (s1_q.cls == BLK_C) state_d = RX_C;
            else if (s1_q.cls == BLK_D) state_d = RX_D;
            else if (s1_q.cls == BLK_T && nxt_ok) state_d = RX_T;
          end
          default: begin
            if (s1_q.cls == BLK_C) state_d = RX_C;
            else if (s1_q.cls == BLK_S) state_d = RX_D;
          end
        endcase
        if (state_d == RX_E) begin
          rxd_d = {8{XGMII_ERROR}};
          rxc_d = 8'hff;
          seq_d = 1'b1;
        end else begin
          rxd_d = s1_q.rxd;
          rxc_d = s1_q.rxc;
        end
      end
    end
  end

  assign xgmii_rxd         = rxd_q;
  assign xgmii_rxc         = rxc_q;
  assign xgmii_rx_valid    = valid_q;
  assign rx_bad_block      = bad_q;
  assign rx_sequence_error = seq_q;

endmodule
